// File: rtl/muldiv_iter_if.sv
// Request/response bundle for the iterative RISC-V M-extension unit.
interface muldiv_iter_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output in_valid, op, operand_a, operand_b, flush, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, op, operand_a, operand_b, flush, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/muldiv_iter.sv
// Multi-cycle MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, one radix-2 step per cycle.
// Define MULDIV_FAST_MUL_EN to run ops 0-3 through a single-cycle multiplier.
module muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  muldiv_iter_if.slave bus
);
  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [XLEN-1:0] cneg(input logic neg, input logic [XLEN-1:0] v);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cneg2(input logic neg, input logic [2*XLEN-1:0] v);
    return neg ? -v : v;
  endfunction

  state_t            state_q, state_d;
  logic [2:0]        op_q;
  logic              neg_q;
  logic [XLEN-1:0]   opnd_q;
  logic [XLEN-1:0]   hi_q;
  logic [XLEN-1:0]   lo_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   result_q;

  logic              in_ready_c, busy_c, out_valid_c;
  logic              accept;
  logic              signed_a, signed_b, sa, sb, neg_in;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_zero, div_ovf, direct;
  logic [XLEN-1:0]   direct_res;
  logic [XLEN:0]     msum, dshift, ddiff;
  logic [XLEN-1:0]   step_hi, step_lo;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   fin_res;

  // Operand decode: signedness comes from funct3, magnitudes feed the unsigned core
  assign signed_a = (bus.op != 3'd3) & ~(bus.op[2] & bus.op[0]);
  assign signed_b = (bus.op == 3'd0) | (bus.op == 3'd1) | (bus.op == 3'd4) | (bus.op == 3'd6);
  assign sa       = signed_a & bus.operand_a[XLEN-1];
  assign sb       = signed_b & bus.operand_b[XLEN-1];
  assign mag_a    = cneg(sa, bus.operand_a);
  assign mag_b    = cneg(sb, bus.operand_b);
  assign neg_in   = (bus.op[2] & bus.op[1]) ? sa : (sa ^ sb);

  assign div_zero = bus.op[2] & (bus.operand_b == '0);
  assign div_ovf  = bus.op[2] & ~bus.op[0] & (&bus.operand_b) &
                    (bus.operand_a == {1'b1, {(XLEN-1){1'b0}}});
  assign accept   = (state_q == IDLE) & bus.in_valid & ~bus.flush;

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN-1:0] fa, fb, fprod;
  assign fa    = {{XLEN{sa}}, bus.operand_a};
  assign fb    = {{XLEN{sb}}, bus.operand_b};
  assign fprod = fa * fb;
`endif

  always_comb begin
    direct     = 1'b0;
    direct_res = '0;
    if (div_zero) begin
      direct     = 1'b1;
      direct_res = bus.op[1] ? bus.operand_a : '1;
    end else if (div_ovf) begin
      direct     = 1'b1;
      direct_res = bus.op[1] ? '0 : bus.operand_a;
    end
`ifdef MULDIV_FAST_MUL_EN
    else if (!bus.op[2]) begin
      direct     = 1'b1;
      direct_res = (bus.op == 3'd0) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
    end
`endif
  end

  // Iteration step: multiply shifts the {hi,lo} accumulator right, divide shifts it left
  assign msum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign dshift = {hi_q, lo_q[XLEN-1]};
  assign ddiff  = dshift - {1'b0, opnd_q};

  always_comb begin
    if (op_q[2]) begin
      step_hi = ddiff[XLEN] ? dshift[XLEN-1:0] : ddiff[XLEN-1:0];
      step_lo = {lo_q[XLEN-2:0], ~ddiff[XLEN]};
    end else begin
      step_hi = msum[XLEN:1];
      step_lo = {msum[0], lo_q[XLEN-1:1]};
    end
  end

  assign prod_fix = cneg2(neg_q, {step_hi, step_lo});

  always_comb begin
    case (op_q)
      3'd0:             fin_res = prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3: fin_res = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:       fin_res = cneg(neg_q, step_lo);
      default:          fin_res = cneg(neg_q, step_hi);
    endcase
  end

  // FSM: state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM: next state; flush overrides every other request
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.in_valid) state_d = direct ? DONE : CALC;
        CALC:    if (cnt_q == '0) state_d = DONE;
        DONE:    if (bus.out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM: outputs decoded from the state register only
  always_comb begin
    in_ready_c  = (state_q == IDLE);
    busy_c      = (state_q != IDLE);
    out_valid_c = (state_q == DONE);
  end

  // Datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q     <= '0;
      neg_q    <= 1'b0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      op_q   <= bus.op;
      neg_q  <= neg_in;
      hi_q   <= '0;
      cnt_q  <= CNT_W'(XLEN - 1);
      opnd_q <= bus.op[2] ? mag_b : mag_a;
      lo_q   <= bus.op[2] ? mag_a : mag_b;
      if (direct) result_q <= direct_res;
    end else if ((state_q == CALC) && !bus.flush) begin
      hi_q  <= step_hi;
      lo_q  <= step_lo;
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == '0) result_q <= fin_res;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.busy      = busy_c;
  assign bus.out_valid = out_valid_c;
  assign bus.result    = result_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter: directed vector table, randomized ops against
// an arithmetic reference model, and handshake/flush/reset sequences.
module tb_muldiv_iter;
  localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_iter_if #(.XLEN(XLEN)) bus();
  muldiv_iter #(.XLEN(XLEN)) dut (.clock(clk), .reset_n(rst_n), .bus(bus));

  int total  = 0;
  int passed = 0;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    int          ia, ib;
    logic        ovf;
    ia  = $signed(a);
    ib  = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      3'd0, 3'd1: p = 64'(longint'(ia) * longint'(ib));
      3'd2:       p = 64'(longint'(ia) * longint'({32'b0, b}));
      3'd3:       p = {32'b0, a} * {32'b0, b};
      default:    p = '0;
    endcase
    case (o)
      3'd0:             model = p[31:0];
      3'd1, 3'd2, 3'd3: model = p[63:32];
      3'd4:             model = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
      3'd5:             model = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6:             model = (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
      default:          model = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (!o[2]) return MUL_LAT;
    if (b == 0) return 1;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return DIV_LAT;
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.op        = o;
    bus.operand_a = a;
    bus.operand_b = b;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Edges counted with the accepting edge as edge 1
  task automatic wait_done(output int lat);
    lat = 1;
    @(negedge clk);
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    issue(o, a, b);
    wait_done(lat);
    res = bus.result;
    consume();
  endtask

  initial begin
    logic [31:0] res, r0, a, b;
    logic [2:0]  o;
    int          lat, sel;

    bus.in_valid  = 1'b0;
    bus.op        = '0;
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;

    vq.push_back('{"mul_ff",    3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, MUL_LAT});
    vq.push_back('{"mulh_ff",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT});
    vq.push_back('{"mulhsu_ff", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT});
    vq.push_back('{"mulhu_ff",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT});
    vq.push_back('{"div_m7_2",  3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, DIV_LAT});
    vq.push_back('{"rem_m7_2",  3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, DIV_LAT});
    vq.push_back('{"divu_7_2",  3'd5, 32'd7,         32'd2,         32'd3,         DIV_LAT});
    vq.push_back('{"remu_7_2",  3'd7, 32'd7,         32'd2,         32'd1,         DIV_LAT});
    vq.push_back('{"div_5_0",   3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 1});
    vq.push_back('{"divu_5_0",  3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1});
    vq.push_back('{"rem_5_0",   3'd6, 32'd5,         32'd0,         32'd5,         1});
    vq.push_back('{"remu_5_0",  3'd7, 32'd5,         32'd0,         32'd5,         1});
    vq.push_back('{"div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
    vq.push_back('{"rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1});

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  32'(bus.in_ready), 32'd1);
    check("rst_busy",      32'(bus.busy), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result",    bus.result, 32'd0);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      run_op(vq[i].op, vq[i].a, vq[i].b, res, lat);
      check({vq[i].name, "_res"}, res, vq[i].exp);
      check({vq[i].name, "_lat"}, 32'(lat), 32'(vq[i].lat));
    end

    for (int i = 0; i < 40; i++) begin
      o   = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'd0;
      if (sel == 1) b = 32'($urandom_range(1, 15));
      if (sel == 2) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (sel == 3) a = 32'($urandom_range(0, 100));
      run_op(o, a, b, res, lat);
      check($sformatf("rand%0d_op%0d_res", i, o), res, model(o, a, b));
      check($sformatf("rand%0d_op%0d_lat", i, o), 32'(lat), 32'(model_lat(o, a, b)));
    end

    // Flush ten cycles into a DIV, then an immediate MULHU
    issue(3'd4, 32'd1000, 32'd3);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("flush_no_valid", 32'(bus.out_valid), 32'd0);
    end
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    check("flush_in_ready",  32'(bus.in_ready), 32'd1);
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    run_op(3'd3, 32'd3, 32'd5, res, lat);
    check("post_flush_mulhu", res, 32'd0);
    check("post_flush_lat", 32'(lat), 32'(MUL_LAT));

    // Flush in IDLE blocks acceptance
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.flush     = 1'b1;
    bus.op        = 3'd5;
    bus.operand_a = 32'd9;
    bus.operand_b = 32'd0;
    @(posedge clk);
    #1 begin bus.in_valid = 1'b0; bus.flush = 1'b0; end
    @(negedge clk);
    check("idle_flush_busy", 32'(bus.busy), 32'd0);

    // Backpressure on the result
    issue(3'd5, 32'd100, 32'd7);
    wait_done(lat);
    check("bp_result", bus.result, 32'd14);
    r0 = bus.result;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_stable",    bus.result, r0);
      check("bp_in_ready",  32'(bus.in_ready), 32'd0);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    end
    consume();
    @(negedge clk);
    check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    check("bp_release_valid",    32'(bus.out_valid), 32'd0);

    // Asynchronous reset in the middle of CALC
    issue(3'd5, 32'd1000, 32'd3);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy",      32'(bus.busy), 32'd0);
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_result",    bus.result, 32'd0);
    check("arst_in_ready",  32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd0, 32'd6, 32'd7, res, lat);
    check("post_rst_mul", res, 32'd42);
    check("post_rst_lat", 32'(lat), 32'(MUL_LAT));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d", passed, total);
    $fatal(1);
  end
endmodule

// File: doc/muldiv_iter.md
# muldiv_iter

Parametrised, multi-cycle RISC-V M-extension unit. It executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU on XLEN-bit operands with a valid/ready handshake on both sides, one operation in flight at a time. It sits beside the combinational ALU in the execute stage: the ALU keeps RV32I ops, and the pipeline stalls on `busy`. Division follows RISC-V special-case semantics exactly.

## Interface
Parameters:
- `XLEN`, 32, operand/result width; any even value ≥ 8.

Ports:
- `clock`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  request valid
- `in_ready`  out  1  unit can accept; high only in IDLE
- `op`  in  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- `operand_a`  in  XLEN  rs1 / dividend
- `operand_b`  in  XLEN  rs2 / divisor
- `flush`  in  1  abort any in-flight op
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts result
- `result`  out  XLEN  registered result
- `busy`  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE: `in_ready`=1. On `in_valid & ~flush`, latch op, take magnitudes of signed operands, record signs, load counter to XLEN-1, go to CALC.
  - Special cases go straight to DONE instead: divisor 0, or signed overflow (a = 1<<(XLEN-1), b = all-ones, op DIV/REM).
- CALC: one radix-2 step per cycle.
  - Multiply: shift-add into a 2·XLEN accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - When counter = 0, apply sign fixup, register `result`, go to DONE.
- Sign rules:
  - MUL/MULH: both operands signed. MULHSU: a signed, b unsigned. MULHU/DIVU/REMU: unsigned.
  - Quotient sign = sign_a XOR sign_b. Remainder sign = sign_a.
  - MUL returns product[XLEN-1:0]. MULH* return product[2XLEN-1:XLEN].
- Special results:
  - Divide by zero: DIV/DIVU → all-ones; REM/REMU → operand_a.
  - Overflow: DIV → operand_a; REM → 0.
- DONE: `out_valid`=1 and `result` held stable. On `out_ready`, go to IDLE. No new accept in the same cycle.
- `flush` (any state): go to IDLE at the next edge. `out_valid` falls, the pending result is discarded, and `flush` in IDLE blocks acceptance.
- `flush` has priority over `out_ready` and `in_valid`.

## Timing
- Reset values: state IDLE, `out_valid`=0, `result`=0, `busy`=0, `in_ready`=1. Internal accumulators and counter are cleared.
- `reset_n` low mid-operation: outputs take reset values immediately (asynchronous); the operation is lost.
- Normal op: `out_valid` rises XLEN+1 edges after the accepting edge (33 for XLEN=32).
- Special case: `out_valid` rises 1 edge after the accepting edge.
- Minimum issue interval: XLEN+2 cycles with `out_ready` held high (accept, XLEN CALC cycles, DONE).
- `in_ready` and `busy` are decoded from the state register only, with no combinational path from inputs.
- `result` changes only on the edge that enters DONE.

## Configuration
- `MULDIV_FAST_MUL_EN` defined: ops 0–3 use a single-cycle XLEN×XLEN (signed-extended to XLEN+1) combinational multiplier.
  - They go IDLE→DONE in 1 edge.
  - Division stays iterative.
- Not defined: all ops are iterative with the latencies above; no hardware multiplier is inferred.

## Test plan
- XLEN=32, a=b=0xFFFFFFFF:
  - MUL→0x00000001, MULH→0x00000000, MULHU→0xFFFFFFFE, MULHSU→0xFFFFFFFF.
  - `out_valid` at edge 33 (edge 1 with `MULDIV_FAST_MUL_EN`).
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 7/2 → 3; REMU 7/2 → 1; each at edge 33.
- Divide by zero:
  - DIV 5/0 and DIVU 5/0 → 0xFFFFFFFF; REM 5/0 and REMU 5/0 → 5; latency 1 edge.
  - Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0; latency 1 edge.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` rises.
  - Expect `result` stable and `in_ready`=0 throughout.
  - On the `out_ready` pulse, IDLE next cycle and `in_ready`=1.
- `flush` 10 cycles into a DIV: `out_valid` never asserts and `in_ready`=1 next cycle.
  - An immediately following MULHU 3×5 returns 0.
- Drop `reset_n` mid-CALC: `busy`/`out_valid`/`result`=0 without a clock edge.
  - After release, a MUL 6×7 returns 42.
